serial_word_loader: RTL and testbench

- Upstream feeder for the 3-bit load-enabled storage register.
- Deserialises a single-bit stream into WIDTH-bit words.
- For each completed word, presents it on a parallel bus with a one-cycle load strobe; the downstream register captures it on its next rising clock edge.
- Tracks partial-word progress, supports synchronous flush, and optionally checks a trailing even-parity bit.

---
 rtl/serial_loader_pkg.sv | 23 ++
 rtl/bit_counter.sv | 40 ++++
 rtl/serial_word_loader.sv | 144 ++++++++++++++
 tb/tb_serial_word_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_loader_pkg.sv
// Shared state encoding and counter sizing for the serial word loader.
package serial_loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_e;

   // Bits needed to hold any value in 0..value-1.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bit_counter.sv
// Mod-N up counter with synchronous clear, enable and a terminal-count strobe
// that is high on the enabled edge that wraps the count back to 0.
module bit_counter #(
   parameter int N  = 3,
   parameter int CW = 3
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear_i,
   input  logic          en_i,
   output logic [CW-1:0] count_o,
   output logic          tc_o
);

   localparam logic [CW-1:0] TERM = CW'(N - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign tc_o    = en_i && (count_q == TERM);
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = tc_o ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/serial_word_loader.sv
// Deserialises a bit stream into WIDTH-bit words with a one-cycle load strobe.
// Define SERIAL_LOADER_PARITY_EN to append and check a trailing even-parity bit.
module serial_word_loader
   import serial_loader_pkg::*;
#(
   parameter int WIDTH     = 3,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             flush,
   output logic [WIDTH-1:0] word_out,
   output logic             load,
   output logic             busy,
   output logic             parity_err
);

`ifdef SERIAL_LOADER_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int CW = clog2(WIDTH + 2);
   localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] word_q,  word_d;
   logic             load_q,  load_d;
   logic [WIDTH-1:0] shifted;
   logic [CW-1:0]    count_q;
   logic             accept;
   logic             frame_done;

   // flush outranks bit_valid: a bit on a flush edge is never counted.
   assign accept = bit_valid && !flush;

   bit_counter #(
      .N  (FRAME),
      .CW (CW)
   ) u_bit_counter (
      .clock   (clock),
      .reset   (reset),
      .clear_i (flush),
      .en_i    (accept),
      .count_o (count_q),
      .tc_o    (frame_done)
   );

   always_comb begin
      if (MSB_FIRST) begin
         shifted = {shift_q[WIDTH-2:0], bit_in};
      end else begin
         shifted = {bit_in, shift_q[WIDTH-1:1]};
      end
   end

`ifdef SERIAL_LOADER_PARITY_EN
   logic perr_q, perr_d;
`endif

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      word_d  = word_q;
      load_d  = 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
      perr_d  = 1'b0;
`endif
      if (flush) begin
         state_d = IDLE;
      end else if (bit_valid) begin
         unique case (state_q)
            IDLE, SHIFT: begin
               shift_d = shifted;
               if (count_q != LAST_DATA) begin
                  state_d = SHIFT;
               end else begin
`ifdef SERIAL_LOADER_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = IDLE;
`endif
               end
`ifndef SERIAL_LOADER_PARITY_EN
               if (frame_done) begin
                  word_d = shifted;
                  load_d = 1'b1;
               end
`endif
            end
`ifdef SERIAL_LOADER_PARITY_EN
            PARITY: begin
               // The incoming bit is the parity bit; even parity over the frame.
               if (frame_done) begin
                  state_d = IDLE;
                  if (^{shift_q, bit_in}) begin
                     perr_d = 1'b1;
                  end else begin
                     word_d = shift_q;
                     load_d = 1'b1;
                  end
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         word_q  <= '0;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         load_q  <= load_d;
      end
   end

`ifdef SERIAL_LOADER_PARITY_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

   assign word_out = word_q;
   assign load     = load_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader: MSB-first and LSB-first instances share stimulus
// and are checked against a bit-queue reference model plus directed vectors.
module tb_serial_word_loader;

  localparam int W = 3;
`ifdef SERIAL_LOADER_PARITY_EN
  localparam int FRAME = W + 1;
  localparam bit PAR   = 1'b1;
`else
  localparam int FRAME = W;
  localparam bit PAR   = 1'b0;
`endif

  // clock / reset
  logic clock     = 1'b0;
  logic reset     = 1'b1;
  logic bit_valid = 1'b0;
  logic bit_in    = 1'b0;
  logic flush     = 1'b0;

  always #5 clock = ~clock;

  logic [W-1:0] word_msb, word_lsb;
  logic         load_msb, load_lsb, busy_msb, busy_lsb, perr_msb, perr_lsb;

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clock      (clock),
    .reset      (reset),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .flush      (flush),
    .word_out   (word_msb),
    .load       (load_msb),
    .busy       (busy_msb),
    .parity_err (perr_msb)
  );

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clock      (clock),
    .reset      (reset),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .flush      (flush),
    .word_out   (word_lsb),
    .load       (load_lsb),
    .busy       (busy_lsb),
    .parity_err (perr_lsb)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // reference model: the pending frame is simply a queue of received bits
  bit           m_bits[$];
  logic [W-1:0] m_word_msb, m_word_lsb;
  logic         m_load, m_perr, m_busy;

  task automatic model_reset();
    m_bits     = {};
    m_word_msb = '0;
    m_word_lsb = '0;
    m_load     = 1'b0;
    m_perr     = 1'b0;
    m_busy     = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic f);
    int ones;
    m_load = 1'b0;
    m_perr = 1'b0;
    if (f) begin
      m_bits = {};
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() == FRAME) begin
        ones = 0;
        for (int i = 0; i < FRAME; i++) ones += int'(m_bits[i]);
        if (!PAR || (ones % 2 == 0)) begin
          for (int i = 0; i < W; i++) begin
            m_word_msb[W-1-i] = m_bits[i];
            m_word_lsb[i]     = m_bits[i];
          end
          m_load = 1'b1;
          exp_q.push_back(m_word_msb);
        end else begin
          m_perr = 1'b1;
        end
        m_bits = {};
      end
    end
    m_busy = (m_bits.size() != 0);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    cmp("msb_word", 32'(word_msb), 32'(m_word_msb));
    cmp("lsb_word", 32'(word_lsb), 32'(m_word_lsb));
    cmp("msb_load", 32'(load_msb), 32'(m_load));
    cmp("lsb_load", 32'(load_lsb), 32'(m_load));
    cmp("msb_busy", 32'(busy_msb), 32'(m_busy));
    cmp("lsb_busy", 32'(busy_lsb), 32'(m_busy));
    cmp("msb_perr", 32'(perr_msb), 32'(m_perr));
    cmp("lsb_perr", 32'(perr_lsb), 32'(m_perr));
    if (load_msb) begin
      if (exp_q.size() == 0) begin
        cmp("sb_unexpected_load", 32'(1), 32'(0));
      end else begin
        cmp("sb_word", 32'(word_msb), 32'(exp_q.pop_front()));
      end
    end
  endtask

  // driver: present inputs, let one rising edge pass, check on the falling edge
  task automatic drive(input logic v, input logic b, input logic f);
    bit_valid = v;
    bit_in    = b;
    flush     = f;
    if (reset) model_reset();
    else       model_step(v, b, f);
    @(negedge clock);
    check_all();
  endtask

  typedef struct {
    logic       v, b, f;
    logic       exp_load, exp_busy, exp_perr;
    logic [2:0] exp_msb, exp_lsb;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic v, input logic b, input logic f,
                         input logic l, input logic bz, input logic pe,
                         input logic [2:0] wm, input logic [2:0] wl);
    vec_t t;
    t.v = v; t.b = b; t.f = f;
    t.exp_load = l; t.exp_busy = bz; t.exp_perr = pe;
    t.exp_msb = wm; t.exp_lsb = wl;
    vecs.push_back(t);
  endtask

  logic [3:0] fresh_bits;

  initial begin
`ifdef SERIAL_LOADER_PARITY_EN
    // data 1,0,1 parity 0 -> load; data 1,1,1 parity 0 -> parity error
    add_vec(1,1,0, 0,1,0, 3'b000, 3'b000);
    add_vec(1,0,0, 0,1,0, 3'b000, 3'b000);
    add_vec(1,1,0, 0,1,0, 3'b000, 3'b000);
    add_vec(1,0,0, 1,0,0, 3'b101, 3'b101);
    add_vec(0,0,0, 0,0,0, 3'b101, 3'b101);
    add_vec(1,1,0, 0,1,0, 3'b101, 3'b101);
    add_vec(1,1,0, 0,1,0, 3'b101, 3'b101);
    add_vec(1,1,0, 0,1,0, 3'b101, 3'b101);
    add_vec(1,0,0, 0,0,1, 3'b101, 3'b101);
    add_vec(0,0,0, 0,0,0, 3'b101, 3'b101);
`else
    // bits 1,0,1 consecutive
    add_vec(1,1,0, 0,1,0, 3'b000, 3'b000);
    add_vec(1,0,0, 0,1,0, 3'b000, 3'b000);
    add_vec(1,1,0, 1,0,0, 3'b101, 3'b101);
    add_vec(0,0,0, 0,0,0, 3'b101, 3'b101);
    // 1, gap 2, 1, gap 1, 0
    add_vec(1,1,0, 0,1,0, 3'b101, 3'b101);
    add_vec(0,0,0, 0,1,0, 3'b101, 3'b101);
    add_vec(0,1,0, 0,1,0, 3'b101, 3'b101);
    add_vec(1,1,0, 0,1,0, 3'b101, 3'b101);
    add_vec(0,0,0, 0,1,0, 3'b101, 3'b101);
    add_vec(1,0,0, 1,0,0, 3'b110, 3'b011);
    add_vec(0,0,0, 0,0,0, 3'b110, 3'b011);
    // 1,1, flush with a bit, then 0,0,1
    add_vec(1,1,0, 0,1,0, 3'b110, 3'b011);
    add_vec(1,1,0, 0,1,0, 3'b110, 3'b011);
    add_vec(1,0,1, 0,0,0, 3'b110, 3'b011);
    add_vec(1,0,0, 0,1,0, 3'b110, 3'b011);
    add_vec(1,0,0, 0,1,0, 3'b110, 3'b011);
    add_vec(1,1,0, 1,0,0, 3'b001, 3'b100);
    add_vec(0,0,0, 0,0,0, 3'b001, 3'b100);
    // continuous 1,0,1,0,1,1
    add_vec(1,1,0, 0,1,0, 3'b001, 3'b100);
    add_vec(1,0,0, 0,1,0, 3'b001, 3'b100);
    add_vec(1,1,0, 1,0,0, 3'b101, 3'b101);
    add_vec(1,0,0, 0,1,0, 3'b101, 3'b101);
    add_vec(1,1,0, 0,1,0, 3'b101, 3'b101);
    add_vec(1,1,0, 1,0,0, 3'b011, 3'b110);
    add_vec(0,0,0, 0,0,0, 3'b011, 3'b110);
    // flush in IDLE is a no-op; then 1,0,0 (LSB-first gives 001)
    add_vec(0,0,1, 0,0,0, 3'b011, 3'b110);
    add_vec(1,1,0, 0,1,0, 3'b011, 3'b110);
    add_vec(1,0,0, 0,1,0, 3'b011, 3'b110);
    add_vec(1,0,0, 1,0,0, 3'b100, 3'b001);
    add_vec(0,0,0, 0,0,0, 3'b100, 3'b001);
`endif

    model_reset();
    repeat (3) @(negedge clock);
    cmp("reset_word", 32'(word_msb), 32'(0));
    cmp("reset_load", 32'(load_msb), 32'(0));
    cmp("reset_busy", 32'(busy_msb), 32'(0));
    cmp("reset_perr", 32'(perr_msb), 32'(0));
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].b, vecs[i].f);
      cmp($sformatf("vec%0d_load", i), 32'(load_msb), 32'(vecs[i].exp_load));
      cmp($sformatf("vec%0d_busy", i), 32'(busy_msb), 32'(vecs[i].exp_busy));
      cmp($sformatf("vec%0d_perr", i), 32'(perr_msb), 32'(vecs[i].exp_perr));
      cmp($sformatf("vec%0d_msb_word", i), 32'(word_msb), 32'(vecs[i].exp_msb));
      cmp($sformatf("vec%0d_lsb_word", i), 32'(word_lsb), 32'(vecs[i].exp_lsb));
    end

    // reset in the middle of a word takes effect without a clock edge
    drive(1, 1, 0);
    drive(1, 1, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    cmp("midreset_word", 32'(word_msb), 32'(0));
    cmp("midreset_busy", 32'(busy_msb), 32'(0));
    cmp("midreset_lsb_word", 32'(word_lsb), 32'(0));
    drive(0, 0, 0);
    reset = 1'b0;
    fresh_bits = 4'b0011; // sent LSB first: 1,1,0 then parity 0
    for (int i = 0; i < FRAME; i++) drive(1, fresh_bits[i], 0);
    cmp("fresh_load", 32'(load_msb), 32'(1));
    cmp("fresh_msb_word", 32'(word_msb), 32'(3'b110));
    cmp("fresh_lsb_word", 32'(word_lsb), 32'(3'b011));
    drive(0, 0, 0);

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end
    reset = 1'b0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    cmp("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
